// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: decides when the ball/paddle graphics run or freeze,
// keeps the two-digit BCD score and the remaining balls, and times the pause
// after a miss and after game over using the per-frame tick.
//
// Handshake note: there is no valid/ready traffic in this block. frame_tick,
// hit and miss are single-cycle pulses sampled on the rising clock edge, and
// button is a level that is sampled on every edge in which it matters.
module pong_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] button,
    input  logic       hit,
    input  logic       miss,
    output logic       graph_still,
    output logic [1:0] msg_sel,
    output logic [7:0] score_bcd,
    output logic [1:0] lives,
    output logic [1:0] state
);

    // The pause timer has to hold WAIT_FRAMES itself, so it needs
    // clog2(WAIT_FRAMES+1) bits.
    localparam int TW = $clog2(WAIT_FRAMES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_FRAMES);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = '0;

    // The lives counter is only two bits wide. Clamp the reload value into
    // 1..3 so that an out-of-range parameter cannot wrap it.
    localparam int LIVES_CLAMPED = (LIVES < 1) ? 1 : ((LIVES > 3) ? 3 : LIVES);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES_CLAMPED);

    // The encoding is visible on the debug port, so it is fixed explicitly.
    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] MSG_SCORE = 2'b00;
    localparam logic [1:0] MSG_START = 2'b01;
    localparam logic [1:0] MSG_OVER  = 2'b10;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    lives_q;
    logic [1:0]    lives_d;
    logic [7:0]    score_q;
    logic [7:0]    score_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          still_q;
    logic          still_d;
    logic [1:0]    msg_q;
    logic [1:0]    msg_d;
    logic          start_req;
    logic          timer_done;

    // Two-digit BCD increment. Units wrap 9->0 with a carry into the tens,
    // and the tens wrap 9->0, so the score runs 99 -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = s[7:4];
        units = s[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    // Any nonzero button value is a start or serve request.
    assign start_req  = (button != 2'b00);
    assign timer_done = (timer_q == TIMER_ZERO);

    // Next-state logic and datapath updates. A miss beats a hit in the same
    // cycle. A timer load beats a frame_tick in the same cycle, because the
    // tick is only looked at in the pause states and the load happens in PLAY.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        timer_d = timer_q;
        case (state_q)
            NEWGAME: begin
                if (start_req) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                    score_d = 8'h00;
                end
            end
            PLAY: begin
                if (miss) begin
                    timer_d = TIMER_LOAD;
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = NEWBALL;
                    end
                end else if (hit) begin
                    score_d = bcd_inc(score_q);
                end
            end
            NEWBALL: begin
                // The timer has to run out first. Only then does a held
                // button serve the next ball.
                if (!timer_done) begin
                    if (frame_tick) begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end else if (start_req) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (!timer_done) begin
                    if (frame_tick) begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end else begin
                    state_d = NEWGAME;
                end
            end
            default: begin
                state_d = NEWGAME;
            end
        endcase
    end

    // Moore output decode from the next state. It is registered below, so
    // the outputs come straight from flops and always match the state.
    always_comb begin
        still_d = 1'b1;
        msg_d   = MSG_SCORE;
        case (state_d)
            NEWGAME: begin
                still_d = 1'b1;
                msg_d   = MSG_START;
            end
            PLAY: begin
                still_d = 1'b0;
                msg_d   = MSG_SCORE;
            end
            NEWBALL: begin
                still_d = 1'b1;
                msg_d   = MSG_SCORE;
            end
            OVER: begin
                still_d = 1'b1;
                msg_d   = MSG_OVER;
            end
            default: begin
                still_d = 1'b1;
                msg_d   = MSG_START;
            end
        endcase
    end

    // State, datapath and output registers. Reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            lives_q <= LIVES_INIT;
            score_q <= 8'h00;
            timer_q <= TIMER_ZERO;
            still_q <= 1'b1;
            msg_q   <= MSG_START;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            timer_q <= timer_d;
            still_q <= still_d;
            msg_q   <= msg_d;
        end
    end

    assign graph_still = still_q;
    assign msg_sel     = msg_q;
    assign score_bcd   = score_q;
    assign lives       = lives_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl with LIVES=3 and WAIT_FRAMES=4. A game-level model
// tracks the mode, the score as a plain integer, the lives and the pause
// timer. Every negedge the DUT outputs are compared with that model. Directed
// scenarios add literal checks that pin the model itself.
module tb_pong_game_ctrl;

    localparam int LIVES = 3;
    localparam int WAIT  = 4;

    // Mode codes as they appear on the debug port.
    localparam int M_NEWGAME = 0;
    localparam int M_PLAY    = 1;
    localparam int M_NEWBALL = 2;
    localparam int M_OVER    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] button = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       graph_still;
    logic [1:0] msg_sel;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Model state: the score is an ordinary integer 0..99.
    int m_mode  = M_NEWGAME;
    int m_score = 0;
    int m_lives = LIVES;
    int m_timer = 0;

    pong_game_ctrl #(.LIVES(LIVES), .WAIT_FRAMES(WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .button(button),
        .hit(hit),
        .miss(miss),
        .graph_still(graph_still),
        .msg_sel(msg_sel),
        .score_bcd(score_bcd),
        .lives(lives),
        .state(state)
    );

    // Clock and reset: 10 ns period. Reset is driven from the main sequence.
    always #5 clk = ~clk;

    // Game-rule model, advanced on every rising edge or an async reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  = M_NEWGAME;
            m_score = 0;
            m_lives = LIVES;
            m_timer = 0;
        end else begin
            case (m_mode)
                M_NEWGAME: if (button != 0) begin
                    m_mode = M_PLAY; m_lives = LIVES; m_score = 0;
                end
                M_PLAY: if (miss) begin
                    m_timer = WAIT;
                    m_lives = m_lives - 1;
                    m_mode  = (m_lives == 0) ? M_OVER : M_NEWBALL;
                end else if (hit) begin
                    m_score = (m_score + 1) % 100;
                end
                M_NEWBALL: if (m_timer > 0) begin
                    if (frame_tick) m_timer = m_timer - 1;
                end else if (button != 0) begin
                    m_mode = M_PLAY;
                end
                default: if (m_timer > 0) begin
                    if (frame_tick) m_timer = m_timer - 1;
                end else begin
                    m_mode = M_NEWGAME;
                end
            endcase
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every negedge, the DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mdl_state", {6'b0, state}, 8'(m_mode));
            chk("mdl_score", score_bcd, to_bcd(m_score));
            chk("mdl_lives", {6'b0, lives}, 8'(m_lives));
            chk("mdl_still", {7'b0, graph_still}, {7'b0, (m_mode != M_PLAY)});
            chk("mdl_msg", {6'b0, msg_sel},
                (m_mode == M_NEWGAME) ? 8'd1 : ((m_mode == M_OVER) ? 8'd2 : 8'd0));
        end
    end

    // Driver: apply one cycle of inputs from a negedge to the next negedge.
    task automatic cyc(input logic [1:0] b, input logic h, input logic m, input logic t);
        button = b; hit = h; miss = m; frame_tick = t;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [7:0] sc,
                           input logic [1:0] lv, input logic gs, input logic [1:0] ms);
        chk({tag, "_state"}, {6'b0, state}, {6'b0, st});
        chk({tag, "_score"}, score_bcd, sc);
        chk({tag, "_lives"}, {6'b0, lives}, {6'b0, lv});
        chk({tag, "_still"}, {7'b0, graph_still}, {7'b0, gs});
        chk({tag, "_msg"}, {6'b0, msg_sel}, {6'b0, ms});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        chk_all("rst", 2'b00, 8'h00, 2'd3, 1'b1, 2'b01);

        // Start the game with a one-cycle button press.
        cyc(2'b01, 0, 0, 0);
        chk_all("start", 2'b01, 8'h00, 2'd3, 1'b0, 2'b00);

        // Scoring: the carry out of the units digit, then the wrap 99 -> 00.
        for (int i = 0; i < 10; i++) cyc(2'b00, 1, 0, 0);
        chk("score10", score_bcd, 8'h10);
        for (int i = 0; i < 89; i++) cyc(2'b00, 1, 0, 0);
        chk("score99", score_bcd, 8'h99);
        cyc(2'b00, 1, 0, 0);
        chk("wrap00", score_bcd, 8'h00);

        // A hit and a miss together: the miss wins and the score is unchanged.
        cyc(2'b00, 1, 1, 0);
        chk_all("hitmiss", 2'b10, 8'h00, 2'd2, 1'b1, 2'b00);

        // Serve: the held button must wait for the timer to run out.
        for (int i = 0; i < 3; i++) cyc(2'b10, 0, 0, 1);
        chk("serve_3tick", {6'b0, state}, 8'h02);
        cyc(2'b10, 0, 0, 1);
        chk("serve_4tick", {6'b0, state}, 8'h02);
        cyc(2'b10, 0, 0, 0);
        chk("serve_play", {6'b0, state}, 8'h01);

        // A frame_tick together with the miss: the load wins and the timer is 4.
        for (int i = 0; i < 3; i++) cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 0, 1, 1);
        chk_all("miss_tick", 2'b10, 8'h03, 2'd1, 1'b1, 2'b00);
        cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 0, 1, 0);
        chk("nb_ign_score", score_bcd, 8'h03);
        chk("nb_ign_lives", {6'b0, lives}, 8'h01);
        for (int i = 0; i < 3; i++) cyc(2'b11, 0, 0, 1);
        cyc(2'b11, 0, 0, 0);
        chk("load_wins", {6'b0, state}, 8'h02);
        cyc(2'b11, 0, 0, 1);
        cyc(2'b11, 0, 0, 0);
        chk("serve2_play", {6'b0, state}, 8'h01);

        // Game over on the last ball.
        cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 0, 1, 0);
        chk_all("over", 2'b11, 8'h05, 2'd0, 1'b1, 2'b10);
        cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 0, 1, 0);
        cyc(2'b01, 0, 0, 0);
        chk_all("over_ign", 2'b11, 8'h05, 2'd0, 1'b1, 2'b10);
        for (int i = 0; i < 3; i++) cyc(2'b00, 0, 0, 1);
        chk("over_3tick", {6'b0, state}, 8'h03);
        cyc(2'b00, 0, 0, 1);
        chk("over_4tick", {6'b0, state}, 8'h03);
        cyc(2'b00, 0, 0, 0);
        chk_all("newgame", 2'b00, 8'h05, 2'd0, 1'b1, 2'b01);

        // Pulses in NEWGAME are ignored.
        cyc(2'b00, 1, 0, 0);
        cyc(2'b00, 0, 1, 0);
        cyc(2'b00, 0, 0, 1);
        chk_all("ng_ign", 2'b00, 8'h05, 2'd0, 1'b1, 2'b01);
        cyc(2'b10, 0, 0, 0);
        chk_all("restart", 2'b01, 8'h00, 2'd3, 1'b0, 2'b00);

        // Reset in the middle of PLAY with score 23 takes effect at once.
        for (int i = 0; i < 23; i++) cyc(2'b00, 1, 0, 0);
        chk("score23", score_bcd, 8'h23);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 2'b00, 8'h00, 2'd3, 1'b1, 2'b01);
        @(negedge clk);
        cyc(2'b01, 1, 0, 1);
        cyc(2'b01, 1, 0, 1);
        chk_all("rst_hold", 2'b00, 8'h00, 2'd3, 1'b1, 2'b01);
        cyc(2'b00, 0, 0, 0);
        #2 reset = 1'b0;
        @(negedge clk);
        chk_all("rst_rel", 2'b00, 8'h00, 2'd3, 1'b1, 2'b01);
        cyc(2'b00, 0, 0, 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
